// File: rtl/frac_pkg.sv
// Shared definitions for the fractional-order operator datapath (FIR numerator and IIR
// denominator stages).
//   WIDTH / FRAC      : sample width and fractional bits of the Q8.24 format
//   AccExt            : guard bits on accumulators so intermediate sums never overflow
//   DefaultA1/A2      : default Q8.24 feedback coefficients for the recursive stage
//   frac_state_e      : sequencing states for the time-multiplexed multiplier
package frac_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned FRAC   = 24;
  localparam int unsigned AccExt = 8;

  // 0.5 and -0.125 in Q8.24
  localparam logic signed [WIDTH-1:0] DefaultA1 = 32'sd8388608;
  localparam logic signed [WIDTH-1:0] DefaultA2 = -32'sd2097152;

  typedef enum logic [1:0] {
    StIdle,
    StMul1,
    StMul2,
    StDone
  } frac_state_e;

endpackage

// File: rtl/frac_sat_q824.sv
// Saturating narrower: clips a guard-extended signed accumulator to a signed WIDTH-bit
// sample.
//   din_i  : signed accumulator value, WIDTH+EXT bits
//   dout_o : value clipped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
//   clip_o : high when din_i was outside that range
module frac_sat_q824 #(
  parameter int unsigned WIDTH = frac_pkg::WIDTH,
  parameter int unsigned EXT   = frac_pkg::AccExt
) (
  input  logic signed [WIDTH+EXT-1:0] din_i,
  output logic        [WIDTH-1:0]     dout_o,
  output logic                        clip_o
);

  // The value fits iff the guard bits and the result sign bit all agree.
  logic [EXT:0] top_bits;
  assign top_bits = din_i[WIDTH+EXT-1:WIDTH-1];

  always_comb begin
    dout_o = din_i[WIDTH-1:0];
    clip_o = 1'b0;
    if (!((&top_bits) || !(|top_bits))) begin
      clip_o = 1'b1;
      dout_o = din_i[WIDTH+EXT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/frac_iir_stage.sv
// Recursive (denominator) section of the fractional-order operator:
//   y[n] = sat(x[n] - A1*y[n-1] - A2*y[n-2]), all Q8.24.
// A single signed multiplier is shared over two cycles (MUL1: A1*y1, MUL2: A2*y2).
//   clk, rst            : clock and synchronous active-high reset
//   in_data/valid/ready : input sample handshake, accepted only in IDLE
//   out_data/valid/ready: saturated result handshake, held stable in DONE
//   out_sat             : result was clipped, meaningful with out_valid
module frac_iir_stage #(
  parameter int unsigned              WIDTH = frac_pkg::WIDTH,
  parameter int unsigned              FRAC  = frac_pkg::FRAC,
  parameter logic signed [WIDTH-1:0]  A1    = frac_pkg::DefaultA1,
  parameter logic signed [WIDTH-1:0]  A2    = frac_pkg::DefaultA2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat
);

  import frac_pkg::*;

  localparam int unsigned AccW  = WIDTH + AccExt;
  localparam int unsigned ProdW = 2 * WIDTH;

  frac_state_e             state_q;
  logic signed [AccW-1:0]  acc_q;
  logic signed [WIDTH-1:0] y1_q, y2_q;

  logic [WIDTH-1:0]        mul_coef, mul_hist;
  logic signed [ProdW-1:0] prod, prod_sh;
  logic signed [AccW-1:0]  acc_sub;
  logic [WIDTH-1:0]        sat_val;
  logic                    sat_clip;
  logic                    unused_prod_hi;

  // Registered-state decode only; no path from out_ready.
  assign in_ready = (state_q == StIdle);

  // Operand mux for the shared multiplier.
  always_comb begin
    mul_coef = A2;
    mul_hist = y2_q;
    if (state_q == StMul1) begin
      mul_coef = A1;
      mul_hist = y1_q;
    end
  end

  // Explicit sign extension keeps the low ProdW bits of the product exact.
  assign prod    = {{WIDTH{mul_coef[WIDTH-1]}}, mul_coef} *
                   {{WIDTH{mul_hist[WIDTH-1]}}, mul_hist};
  assign prod_sh = prod >>> FRAC;  // floor, no rounding

  // |coef*hist| >> FRAC stays below 2^(2*WIDTH-2-FRAC), well inside AccW bits.
  assign acc_sub        = acc_q - prod_sh[AccW-1:0];
  assign unused_prod_hi = ^prod_sh[ProdW-1:AccW];

  frac_sat_q824 #(
    .WIDTH (WIDTH),
    .EXT   (AccExt)
  ) u_sat (
    .din_i  (acc_sub),
    .dout_o (sat_val),
    .clip_o (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            acc_q   <= {{AccExt{in_data[WIDTH-1]}}, in_data};
            state_q <= StMul1;
          end
        end
        StMul1: begin
          acc_q   <= acc_sub;
          state_q <= StMul2;
        end
        StMul2: begin
          out_data  <= sat_val;
          out_sat   <= sat_clip;
          out_valid <= 1'b1;
          // History is fed from the clipped value so the recursion stays bounded.
          y2_q      <= y1_q;
          y1_q      <= sat_val;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_iir_stage.sv
// Self-checking bench for frac_iir_stage: a reference model fills a scoreboard on every
// input handshake; outputs are popped and compared on every output handshake.
module tb_frac_iir_stage;

  localparam longint MaxQ = 64'sd2147483647;
  localparam longint MinQ = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sat;

  always #5 clk = ~clk;

  frac_iir_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  longint      m_y1 = 0;
  longint      m_y2 = 0;
  logic [31:0] exp_data_q[$];
  logic        exp_sat_q[$];
  int          acc_cyc_q[$];
  int          acc_log[$];
  logic [31:0] got_q[$];
  logic        got_sat_q[$];
  logic        ov_prev = 1'b0;

  // Reference model of y[n] = sat(x - floor(0.5*y1) - floor(-0.125*y2)).
  task automatic model(input logic [31:0] x, output logic [31:0] y, output logic s);
    longint acc;
    acc = longint'($signed(x));
    acc = acc - ((longint'(8388608) * m_y1) >>> 24);
    acc = acc - ((longint'(-2097152) * m_y2) >>> 24);
    if (acc > MaxQ) begin
      y = 32'h7FFF_FFFF; s = 1'b1;
    end else if (acc < MinQ) begin
      y = 32'h8000_0000; s = 1'b1;
    end else begin
      y = acc[31:0]; s = 1'b0;
    end
    m_y2 = m_y1;
    m_y1 = longint'($signed(y));
  endtask

  // Runs at the falling edge: inputs and outputs here are what the next rising edge sees.
  task automatic monitor();
    logic [31:0] ed, my;
    logic        es, ms;
    int          a;
    cyc++;
    if (rst) begin
      exp_data_q.delete();
      exp_sat_q.delete();
      acc_cyc_q.delete();
      m_y1    = 0;
      m_y2    = 0;
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        n_tests++;
        if (acc_cyc_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_output: out_valid=1 out_data=%h, required no output", out_data);
        end else begin
          a = acc_cyc_q.pop_front();
          if (cyc - a != 3) begin
            n_fail++;
            $display("FAIL latency: out_valid %0d cycles after accept, required 3", cyc - a);
          end
        end
      end
      if (out_valid && out_ready && exp_data_q.size() != 0) begin
        ed = exp_data_q.pop_front();
        es = exp_sat_q.pop_front();
        n_tests++;
        if (out_data !== ed || out_sat !== es) begin
          n_fail++;
          $display("FAIL scoreboard: out_data=%h out_sat=%b, required %h/%b",
                   out_data, out_sat, ed, es);
        end
        got_q.push_back(out_data);
        got_sat_q.push_back(out_sat);
      end
      if (in_valid && in_ready) begin
        model(in_data, my, ms);
        exp_data_q.push_back(my);
        exp_sat_q.push_back(ms);
        acc_cyc_q.push_back(cyc);
        acc_log.push_back(cyc);
      end
      ov_prev = out_valid;
    end
  endtask

  // One clock: monitor at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got_q.delete();
    got_sat_q.delete();
    acc_log.delete();
  endtask

  task automatic send(input logic [31:0] x);
    int n;
    n        = 0;
    in_data  = x;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_data_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", exp_data_q.size());
    end
    tick();
  endtask

  task automatic check_got(input string name, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] want[2];
    want[0] = w0;
    want[1] = w1;
    n_tests++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL %s_count: %0d outputs, required 2", name, got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        n_fail++;
        $display("FAIL %s_out%0d: got %h, required %h", name, i,
                 (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, want[i]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    n_tests++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data);
    end
    n_tests++;
    if (out_sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_sat: got %b, required 0", out_sat);
    end
  endtask

  task automatic test_impulse();
    logic [31:0] want[4];
    want[0] = 32'd16777216;
    want[1] = -32'sd8388608;
    want[2] = 32'd6291456;
    want[3] = -32'sd4194304;
    do_reset();
    send(32'd16777216);
    send(32'd0);
    send(32'd0);
    send(32'd0);
    drain();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== want[i] || got_sat_q[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL impulse_out%0d: got %h, required %h sat 0", i,
                 (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, want[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (i >= acc_log.size() || acc_log[i] - acc_log[i-1] != 4) begin
        n_fail++;
        $display("FAIL throughput_gap%0d: got %0d cycles, required 4", i,
                 (i < acc_log.size()) ? acc_log[i] - acc_log[i-1] : -1);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    drain();
    check_got("saturation", 32'h7FFF_FFFF, 32'h8000_0000);
    n_tests++;
    if (got_sat_q.size() != 2 || got_sat_q[0] !== 1'b0 || got_sat_q[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation_flags: got %0d flags, required 0 then 1", got_sat_q.size());
    end
  endtask

  task automatic test_truncation();
    do_reset();
    send(32'hFFFF_FFFF);
    send(32'h0);
    drain();
    check_got("truncation", 32'hFFFF_FFFF, 32'h0000_0001);
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    out_ready = 1'b0;
    send(32'd16777216);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    in_data  = 32'h0100_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'd16777216 || out_sat !== 1'b0 ||
          in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: valid=%b data=%h sat=%b in_ready=%b, required 1/01000000/0/0",
                 i, out_valid, out_data, out_sat, in_ready);
      end
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    drain();
    check_got("backpressure", 32'd16777216, 32'd8388608);
    n_tests++;
    if (acc_log.size() != 2) begin
      n_fail++;
      $display("FAIL backpressure_accepts: got %0d accepts, required 2", acc_log.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'd16777216);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet%0d: out_valid=%b, required 0", i, out_valid);
      end
    end
    send(32'd16777216);
    send(32'd0);
    drain();
    check_got("reset_mid", 32'd16777216, -32'sd8388608);
  endtask

  task automatic test_ignored();
    do_reset();
    send(32'd16777216);
    tick();
    in_data  = 32'h1234_5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    send(32'd0);
    drain();
    check_got("ignored", 32'd16777216, -32'sd8388608);
    n_tests++;
    if (acc_log.size() != 2) begin
      n_fail++;
      $display("FAIL ignored_accepts: got %0d accepts, required 2", acc_log.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      r = $urandom();
      send((i % 4 == 0) ? r : {{7{r[24]}}, r[24:0]});
    end
    drain();
    n_tests++;
    if (got_q.size() != 24) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d outputs, required 24", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_truncation();
    test_backpressure();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
